spi_reg_bridge: RTL

//  Byte-level command decoder sitting directly downstream of the SPI slave byte engine.
//  It consumes the received-byte/ready/ack handshake and drives the next transmit byte.
//  It turns CS-framed SPI transactions into reads and writes of a small 8-bit register bank.

---
 rtl/spi_reg_bridge_if.sv | 26 ++
 rtl/spi_reg_bridge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge_if.sv
// Handshake and register-bank bundle between the SPI byte engine side and spi_reg_bridge.
// master = byte engine / board side, slave = the bridge.
interface spi_reg_bridge_if #(
    parameter int NUM_REGS = 8
);
    logic                  spi_cs;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  rx_ack;
    logic [7:0]            tx_data;
    logic [NUM_REGS*8-1:0] regs_flat;
    logic                  wr_pulse;
    logic [6:0]            wr_addr;
    logic [7:0]            wr_data;
    logic                  frame_act;

    modport master (
        output spi_cs, rx_data, rx_ready,
        input  rx_ack, tx_data, regs_flat, wr_pulse, wr_addr, wr_data, frame_act
    );

    modport slave (
        input  spi_cs, rx_data, rx_ready,
        output rx_ack, tx_data, regs_flat, wr_pulse, wr_addr, wr_data, frame_act
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// Decodes CS-framed SPI byte streams into reads/writes of a small 8-bit register bank.
// Optional feature macro: SPI_REG_ID_EN (read-only ID byte at address 7'h7F).
module spi_reg_bridge #(
    parameter int         NUM_REGS = 8,
    parameter logic [7:0] ID_VALUE = 8'h5A
) (
    input logic             system_clk,
    input logic             rst_n,
    spi_reg_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR,
        RD
    } state_e;

    state_e     state_q, state_d;
    logic       csMeta_q, csSync_q, csPrev_q;
    logic [1:0] warm_q;
    logic       rdy_q, rdyPrev_q;
    logic [6:0] addr_q, addr_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] regs_q [NUM_REGS];
    logic       rxAck_q, wrPulse_q;
    logic [6:0] wrAddr_q;
    logic [7:0] wrData_q;

    logic       cs_s, csFall, accept, wrEn;

    assign cs_s   = csSync_q;
    // csPrev_q is held low until the synchroniser carries real pin values, so a CS
    // held low across reset is not mistaken for a fresh frame start.
    assign csFall = csPrev_q & ~cs_s;
    assign accept = rdy_q & ~rdyPrev_q & ~cs_s;

    function automatic logic isMapped(input logic [6:0] a);
`ifdef SPI_REG_ID_EN
        return ({25'd0, a} < 32'(NUM_REGS)) && (a != 7'h7F);
`else
        return ({25'd0, a} < 32'(NUM_REGS));
`endif
    endfunction

    function automatic logic [7:0] rdMux(input logic [6:0] a);
        logic [7:0] rd;
        rd = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == 7'(i)) rd = regs_q[i];
        end
`ifdef SPI_REG_ID_EN
        if (a == 7'h7F) rd = ID_VALUE;
`endif
        return rd;
    endfunction

`ifndef SPI_REG_ID_EN
    logic unusedIdValue;
    assign unusedIdValue = ^ID_VALUE;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        wrEn    = 1'b0;
        if (cs_s) begin
            state_d = IDLE;
            tx_d    = 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (csFall) state_d = CMD;
                end
                CMD: begin
                    if (accept) begin
                        if (bus.rx_data[7]) begin
                            state_d = WR;
                            addr_d  = bus.rx_data[6:0];
                        end else begin
                            state_d = RD;
                            tx_d    = rdMux(bus.rx_data[6:0]);
                            addr_d  = bus.rx_data[6:0] + 7'd1;
                        end
                    end
                end
                WR: begin
                    if (accept) begin
                        wrEn   = isMapped(addr_q);
                        addr_d = addr_q + 7'd1;
                    end
                end
                RD: begin
                    if (accept) begin
                        tx_d   = rdMux(addr_q);
                        addr_d = addr_q + 7'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            csMeta_q  <= 1'b1;
            csSync_q  <= 1'b1;
            csPrev_q  <= 1'b0;
            warm_q    <= 2'b00;
            rdy_q     <= 1'b0;
            rdyPrev_q <= 1'b0;
            state_q   <= IDLE;
            addr_q    <= 7'd0;
            tx_q      <= 8'h00;
            rxAck_q   <= 1'b0;
            wrPulse_q <= 1'b0;
            wrAddr_q  <= 7'd0;
            wrData_q  <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            csMeta_q  <= bus.spi_cs;
            csSync_q  <= csMeta_q;
            warm_q    <= {warm_q[0], 1'b1};
            csPrev_q  <= csSync_q & warm_q[1];
            rdy_q     <= bus.rx_ready;
            rdyPrev_q <= rdy_q;
            state_q   <= state_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            rxAck_q   <= accept;
            wrPulse_q <= wrEn;
            if (wrEn) begin
                wrAddr_q <= addr_q;
                wrData_q <= bus.rx_data;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wrEn && (addr_q == 7'(i))) regs_q[i] <= bus.rx_data;
            end
        end
    end

    assign bus.rx_ack    = rxAck_q;
    assign bus.tx_data   = tx_q;
    assign bus.wr_pulse  = wrPulse_q;
    assign bus.wr_addr   = wrAddr_q;
    assign bus.wr_data   = wrData_q;
    assign bus.frame_act = ~cs_s;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign bus.regs_flat[8*g +: 8] = regs_q[g];
    end

endmodule
